// File: rtl/fetch_attr_fifo_param.sv
// fetch_attr_fifo_param: parameterised synchronous FIFO for fetch attributes.
// Ports: clk, rst (async active-low), flush, push/data_in, pop, data_out,
//        valid, full, almost_full, count, overflow_err, underflow_err.
// Optional macro FETCH_ATTR_FIFO_ERR_FLAGS_EN adds sticky error flags.
module fetch_attr_fifo_param #(
    parameter int DATA_WIDTH         = 32,
    parameter int FIFO_DEPTH         = 4,
    parameter int ALMOST_FULL_THRESH = FIFO_DEPTH - 1,
    localparam int CW                = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  full,
    output logic                  almost_full,
    output logic [CW-1:0]         count,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    logic          arm_q, arm_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign count       = count_q;
    assign valid       = (count_q != '0);
    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign almost_full = (int'(count_q) >= ALMOST_FULL_THRESH);

    // arm_q holds off push/pop on the first edge after reset release.
    assign push_ok = arm_q && !flush && push && (!full || pop);
    assign pop_ok  = arm_q && !flush && pop && valid;

    always_comb begin
        arm_d   = 1'b1;
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arm_q   <= 1'b0;
            count_q <= '0;
        end else begin
            arm_q   <= arm_d;
            count_q <= count_d;
        end
    end

    generate
        if (FIFO_DEPTH == 1) begin : g_single
            // count_q doubles as the valid bit of the single entry.
            logic [DATA_WIDTH-1:0] data_q;

            always_ff @(posedge clk) begin
                if (push_ok) data_q <= data_in;
            end

            assign data_out = data_q;
        end else begin : g_multi
            localparam int IW = $clog2(FIFO_DEPTH);

            logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
            logic [IW-1:0]         rd_q, rd_d;
            logic [IW-1:0]         wr_q, wr_d;

            always_comb begin
                rd_d = rd_q;
                wr_d = wr_q;
                if (flush) begin
                    rd_d = '0;
                    wr_d = '0;
                end else begin
                    if (pop_ok) begin
                        rd_d = (rd_q == IW'(FIFO_DEPTH - 1)) ? '0
                                                             : rd_q + IW'(1);
                    end
                    if (push_ok) begin
                        wr_d = (wr_q == IW'(FIFO_DEPTH - 1)) ? '0
                                                             : wr_q + IW'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rd_q <= '0;
                    wr_q <= '0;
                end else begin
                    rd_q <= rd_d;
                    wr_q <= wr_d;
                end
            end

            // At full with a pop, wr_q equals rd_q, so the new entry
            // lands in the slot being freed.
            always_ff @(posedge clk) begin
                if (push_ok) mem_q[wr_q] <= data_in;
            end

            assign data_out = mem_q[rd_q];
        end
    endgenerate

`ifdef FETCH_ATTR_FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q | (arm_q && !flush && push && full && !pop);
        unf_d = unf_q | (arm_q && !flush && pop && !valid);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;
`else
    assign overflow_err  = 1'b0;
    assign underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_attr_fifo_param.sv
// tb_fetch_attr_fifo_param: directed bench for a depth-3 and a depth-1 FIFO.
// Expected values are hand-derived constants.
module tb_fetch_attr_fifo_param;

`ifdef FETCH_ATTR_FIFO_ERR_FLAGS_EN
    localparam logic EF = 1'b1;
`else
    localparam logic EF = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       flush, push, pop;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       valid, full, almost_full;
    logic [1:0] count;
    logic       ovf, unf;

    logic       p1_push, p1_pop, p1_flush;
    logic [7:0] p1_din, p1_dout;
    logic       p1_valid, p1_full, p1_af;
    logic [0:0] p1_count;
    logic       p1_ovf, p1_unf;

    int n_chk;
    int n_fail;

    fetch_attr_fifo_param #(
        .DATA_WIDTH(8),
        .FIFO_DEPTH(3)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push(push), .data_in(data_in), .pop(pop),
        .data_out(data_out), .valid(valid), .full(full),
        .almost_full(almost_full), .count(count),
        .overflow_err(ovf), .underflow_err(unf)
    );

    fetch_attr_fifo_param #(
        .DATA_WIDTH(8),
        .FIFO_DEPTH(1)
    ) dut1 (
        .clk(clk), .rst(rst), .flush(p1_flush),
        .push(p1_push), .data_in(p1_din), .pop(p1_pop),
        .data_out(p1_dout), .valid(p1_valid), .full(p1_full),
        .almost_full(p1_af), .count(p1_count),
        .overflow_err(p1_ovf), .underflow_err(p1_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic ps, input logic [7:0] d,
                       input logic pp, input logic fl);
        push    = ps;
        data_in = d;
        pop     = pp;
        flush   = fl;
        @(posedge clk);
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
    endtask

    task automatic cyc1(input logic ps, input logic [7:0] d,
                        input logic pp);
        p1_push = ps;
        p1_din  = d;
        p1_pop  = pp;
        @(posedge clk);
        #1;
        p1_push = 1'b0;
        p1_pop  = 1'b0;
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rst      = 1'b0;
        flush    = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        data_in  = 8'h00;
        p1_push  = 1'b0;
        p1_pop   = 1'b0;
        p1_flush = 1'b0;
        p1_din   = 8'h00;

        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_unf", 32'(unf), 0);
        chk("d1_rst_af", 32'(p1_af), 1);
        chk("d1_rst_valid", 32'(p1_valid), 0);

        #10 rst = 1'b1;

        // First edge after release: push must not take effect.
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("guard_count", 32'(count), 0);

        cyc(1'b1, 8'hA1, 1'b0, 1'b0);
        chk("p1_count", 32'(count), 1);
        chk("p1_head", 32'(data_out), 32'hA1);
        cyc(1'b1, 8'hA2, 1'b0, 1'b0);
        chk("p2_af", 32'(almost_full), 1);
        chk("p2_full", 32'(full), 0);
        cyc(1'b1, 8'hA3, 1'b0, 1'b0);
        chk("p3_full", 32'(full), 1);
        chk("p3_count", 32'(count), 3);
        chk("p3_af", 32'(almost_full), 1);

        chk("pop_a1", 32'(data_out), 32'hA1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pop_a2", 32'(data_out), 32'hA2);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pop_a3", 32'(data_out), 32'hA3);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("empty_valid", 32'(valid), 0);
        chk("empty_count", 32'(count), 0);

        cyc(1'b1, 8'hA1, 1'b0, 1'b0);
        cyc(1'b1, 8'hA2, 1'b0, 1'b0);
        cyc(1'b1, 8'hA3, 1'b0, 1'b0);

        cyc(1'b1, 8'hC0, 1'b0, 1'b0);
        chk("drop_count", 32'(count), 3);
        chk("drop_head", 32'(data_out), 32'hA1);
        chk("drop_ovf", 32'(ovf), 32'(EF));

        cyc(1'b1, 8'hB4, 1'b1, 1'b0);
        chk("fpp_count", 32'(count), 3);
        chk("fpp_head", 32'(data_out), 32'hA2);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fpp_a3", 32'(data_out), 32'hA3);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_b4", 32'(data_out), 32'hB4);
        chk("wrap_count", 32'(count), 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_valid", 32'(valid), 0);

        cyc(1'b1, 8'hD5, 1'b1, 1'b0);
        chk("epp_count", 32'(count), 1);
        chk("epp_head", 32'(data_out), 32'hD5);
        chk("epp_unf", 32'(unf), 32'(EF));

        cyc(1'b1, 8'hE1, 1'b0, 1'b0);
        chk("pre_flush", 32'(count), 2);
        cyc(1'b1, 8'hF0, 1'b1, 1'b1);
        chk("flush_count", 32'(count), 0);
        chk("flush_valid", 32'(valid), 0);
        chk("flush_ovf", 32'(ovf), 32'(EF));
        chk("flush_unf", 32'(unf), 32'(EF));

        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        chk("rf_head", 32'(data_out), 32'h11);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        chk("pre_arst", 32'(count), 2);

        #3 rst = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_valid", 32'(valid), 0);
        chk("arst_ovf", 32'(ovf), 0);
        #2 rst = 1'b1;

        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        chk("arst_guard", 32'(count), 0);
        cyc(1'b1, 8'h44, 1'b0, 1'b0);
        chk("arst_push_cnt", 32'(count), 1);
        chk("arst_push_head", 32'(data_out), 32'h44);

        cyc1(1'b1, 8'h5A, 1'b0);
        chk("d1_full", 32'(p1_full), 1);
        chk("d1_head", 32'(p1_dout), 32'h5A);
        cyc1(1'b1, 8'h6B, 1'b0);
        chk("d1_drop", 32'(p1_dout), 32'h5A);
        chk("d1_ovf", 32'(p1_ovf), 32'(EF));
        cyc1(1'b1, 8'h7C, 1'b1);
        chk("d1_pp_head", 32'(p1_dout), 32'h7C);
        chk("d1_pp_cnt", 32'(p1_count), 1);
        cyc1(1'b0, 8'h00, 1'b1);
        chk("d1_empty", 32'(p1_valid), 0);
        cyc1(1'b1, 8'h8D, 1'b1);
        chk("d1_epp_head", 32'(p1_dout), 32'h8D);
        chk("d1_epp_cnt", 32'(p1_count), 1);
        chk("d1_unf", 32'(p1_unf), 32'(EF));

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_attr_fifo_param.md
FETCH_ATTR_FIFO_PARAM -- requirements
Module: fetch_attr_fifo_param

Interface
REQ-001 Parameter DATA_WIDTH, default 32, bit width of each stored entry.
REQ-002 Parameter FIFO_DEPTH, default 4, number of entries; any value from 1 to 64 SHALL be legal, and depth SHALL NOT be rounded to a power of 2.
REQ-003 Parameter ALMOST_FULL_THRESH, default FIFO_DEPTH-1, occupancy at or above which almost_full asserts.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  synchronous clear of all entries.
REQ-007 push  input  1  enqueue data_in this cycle.
REQ-008 data_in  input  DATA_WIDTH  entry to enqueue.
REQ-009 pop  input  1  dequeue the head entry this cycle.
REQ-010 data_out  output  DATA_WIDTH  head entry; defined only while valid=1.
REQ-011 valid  output  1  at least one entry held.
REQ-012 full  output  1  count == FIFO_DEPTH.
REQ-013 almost_full  output  1  count >= ALMOST_FULL_THRESH.
REQ-014 count  output  $clog2(FIFO_DEPTH+1)  current occupancy.
REQ-015 overflow_err  output  1  sticky flag: a push was dropped.
REQ-016 underflow_err  output  1  sticky flag: a pop was ignored.

Function
REQ-017 Occupancy: count SHALL update each cycle as count + accepted_push - accepted_pop, with no wrap.
REQ-018 Flags: valid, full and almost_full SHALL be combinational decodes of count only.
REQ-019 Push acceptance: a push SHALL be accepted when full=0, or when full=1 and pop=1 in the same cycle.
REQ-020 Push rejection: a push with full=1 and pop=0 SHALL be dropped with storage and count unchanged.
REQ-021 Pop acceptance: a pop SHALL be accepted only when valid=1.
REQ-022 Pop rejection: a pop with valid=0 SHALL be ignored and SHALL NOT bypass a same-cycle push.
REQ-023 Write latency: data accepted at edge N SHALL appear on data_out (when it is the head) and raise valid from edge N+1.
REQ-024 data_out path: data_out SHALL be a combinational read of storage at the read index; there is no output register.
REQ-025 Simultaneous push and pop with 0 < count < FIFO_DEPTH: both SHALL be accepted and count SHALL be unchanged.
REQ-026 Simultaneous push and pop at full: both SHALL be accepted; the new entry SHALL be written to the slot being freed and count SHALL stay FIFO_DEPTH.
REQ-027 Index wrap: read and write indices SHALL be binary counters that wrap from FIFO_DEPTH-1 to 0.
REQ-028 Ordering: entries SHALL leave strictly in push order.
REQ-029 Flush: flush=1 SHALL set count, read index and write index to 0 at the next edge, overriding push and pop in the same cycle.
REQ-030 Flush and error flags: flush SHALL NOT clear overflow_err or underflow_err.
REQ-031 Depth 1: FIFO_DEPTH=1 SHALL be implemented as a single data register plus a valid bit, with identical port behaviour.
REQ-032 Storage: the storage array SHALL NOT be reset; only indices, count and flags are reset.

Reset
REQ-033 rst=0 SHALL immediately, asynchronously to clk, force count=0, indices=0, valid=0, full=0, almost_full=(ALMOST_FULL_THRESH==0), overflow_err=0 and underflow_err=0.
REQ-034 Reset mid-operation SHALL discard all held entries; no push or pop SHALL take effect on the first edge after rst rises.

Configuration
REQ-035 Macro FETCH_ATTR_FIFO_ERR_FLAGS_EN defined: overflow_err SHALL set on a dropped push and underflow_err SHALL set on an ignored pop; both SHALL stay set until reset.
REQ-036 Macro FETCH_ATTR_FIFO_ERR_FLAGS_EN undefined: overflow_err and underflow_err SHALL be tied to 0, no flag registers SHALL exist, and drop/ignore behaviour SHALL be unchanged.

Verification
REQ-037 FIFO_DEPTH=3: push 0xA1, 0xA2, 0xA3 -> full=1, count=3, almost_full=1; then pop three times -> data_out reads 0xA1, 0xA2, 0xA3 in order, then valid=0.
REQ-038 FIFO_DEPTH=3 full: push 0xB4 with pop=1 -> 0xA1 leaves, count stays 3; after two more pops data_out=0xB4, confirming wrap at index 2->0.
REQ-039 Full with pop=0: push 0xC0 -> count stays 3, contents unchanged; overflow_err=1 with the macro, 0 without it.
REQ-040 Empty: pop=1 with push=1, data 0xD5 -> count=1 next cycle, data_out=0xD5; underflow_err=1 with the macro.
REQ-041 count=2: flush, push and pop all asserted -> count=0, valid=0 next cycle; error flags unchanged.
REQ-042 Assert rst=0 between clock edges with count=2 -> valid=0 and count=0 immediately; first push after rst release appears at the head one cycle later.
